univ_shift_reg: RTL



---
 rtl/univ_shift_reg.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with a per-word
// operation counter.
//
// Operations (when en=1), selected by mode:
//   000 hold, 001 shift right, 010 shift left, 011 rotate right,
//   100 rotate left, 101 parallel load, 110 arithmetic shift right, 111 clear.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (overrides en and mode)
//   en        operation enable; 0 holds q, dout and bit_cnt
//   mode      operation select (see above)
//   din       serial input bit (used by the logical shifts only)
//   pdin      parallel load data
//   q         register contents
//   dout      last bit shifted or rotated out
//   word_done one-cycle pulse when WIDTH shift/rotate ops have completed
//   bit_cnt   shift/rotate ops performed in the current word
//
// All outputs come straight from flops; nothing combinational reaches them.

module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       din,
  input  logic [WIDTH-1:0]           pdin,
  output logic [WIDTH-1:0]           q,
  output logic                       dout,
  output logic                       word_done,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_r;
  logic             dout_r;
  logic             done_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             dout_nxt_s;
  logic             done_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             shift_op_s;

  // Next-state datapath: select the new word and out-bit for the requested mode.
  always_comb begin
    q_nxt_s    = q_r;
    dout_nxt_s = dout_r;
    shift_op_s = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_nxt_s = q_r;
        end
        MODE_SHR: begin
          q_nxt_s    = {din, q_r[WIDTH-1:1]};
          dout_nxt_s = q_r[0];
          shift_op_s = 1'b1;
        end
        MODE_SHL: begin
          q_nxt_s    = {q_r[WIDTH-2:0], din};
          dout_nxt_s = q_r[WIDTH-1];
          shift_op_s = 1'b1;
        end
        MODE_ROR: begin
          q_nxt_s    = {q_r[0], q_r[WIDTH-1:1]};
          dout_nxt_s = q_r[0];
          shift_op_s = 1'b1;
        end
        MODE_ROL: begin
          q_nxt_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          dout_nxt_s = q_r[WIDTH-1];
          shift_op_s = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt_s = pdin;
        end
        MODE_ASR: begin
          // Sign bit is replicated into the vacated MSB.
          q_nxt_s    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          dout_nxt_s = q_r[0];
          shift_op_s = 1'b1;
        end
        MODE_CLEAR: begin
          q_nxt_s    = {WIDTH{1'b0}};
          dout_nxt_s = 1'b0;
        end
        default: begin
          q_nxt_s    = q_r;
          dout_nxt_s = dout_r;
        end
      endcase
    end else begin
      q_nxt_s    = q_r;
      dout_nxt_s = dout_r;
    end
  end

  // Word counter: counts shift/rotate ops regardless of direction; load and
  // clear restart the word without a completion pulse.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    if (en && shift_op_s) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s  = {CW{1'b0}};
        done_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s  = cnt_r + CW'(1);
        done_nxt_s = 1'b0;
      end
    end else if (en && ((mode == MODE_LOAD) || (mode == MODE_CLEAR))) begin
      cnt_nxt_s  = {CW{1'b0}};
      done_nxt_s = 1'b0;
    end else begin
      cnt_nxt_s  = cnt_r;
      done_nxt_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= RESET_VAL;
      dout_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      dout_r <= dout_nxt_s;
      cnt_r  <= cnt_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q         = q_r;
  assign dout      = dout_r;
  assign bit_cnt   = cnt_r;
  assign word_done = done_r;

endmodule
